axis2ram_wr: RTL and testbench



---
 rtl/axis2ram_wr.sv | 140 ++++++++++++++
 tb/tb_axis2ram_wr.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis2ram_wr.sv
`timescale 1ns/1ps
// Packs an AXI-Stream frame of IN_WIDTH samples into DATA_WIDTH RAM words written from address 0 up to all-ones.
// Latency: word write one cycle after its last beat; done two cycles after the final beat; tready depends only on state.
// Backpressure: the RAM never stalls; tready=0 outside FILL. Optional macro AXIS2RAM_BITREV_ADDR_EN gives bit-reversed addresses.
module axis2ram_wr #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 64,
  parameter int IN_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  start,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [IN_WIDTH-1:0]   s_axis_tdata,
  input  logic                  s_axis_tlast,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  busy,
  output logic                  done,
  output logic                  tlast_err
);

  localparam int PACK = DATA_WIDTH / IN_WIDTH;
  localparam int BW   = (PACK > 1) ? $clog2(PACK) : 1;
  localparam logic [BW-1:0]         LAST_BEAT = BW'(PACK - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = '1;

  typedef enum logic [1:0] {IDLE, FILL, FLUSH, DONE} state_t;

  state_t                state_q;
  logic [BW-1:0]         beat_q;
  logic [ADDR_WIDTH-1:0] word_q;
  logic [DATA_WIDTH-1:0] pack_q;
  logic [DATA_WIDTH-1:0] pack_d;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;

  logic beat_acc;
  logic word_end;
  logic final_beat;

  assign s_axis_tready = (state_q == FILL);
  assign beat_acc      = s_axis_tvalid & s_axis_tready;
  assign word_end      = (beat_q == LAST_BEAT);
  assign final_beat    = word_end && (word_q == LAST_WORD);

  // The word being completed is taken from pack_d so the last beat goes straight into the write.
  always_comb begin
    pack_d = pack_q;
    for (int k = 0; k < PACK; k++) begin
      if (beat_q == BW'(k)) begin
        pack_d[k*IN_WIDTH +: IN_WIDTH] = s_axis_tdata;
      end
    end
  end

`ifdef AXIS2RAM_BITREV_ADDR_EN
  always_comb begin
    addr_d = '0;
    for (int i = 0; i < ADDR_WIDTH; i++) begin
      addr_d[i] = word_q[ADDR_WIDTH-1-i];
    end
  end
`else
  assign addr_d = word_q;
`endif

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state_q <= IDLE;
      beat_q  <= '0;
      word_q  <= '0;
      pack_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= FILL;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            beat_q  <= '0;
            word_q  <= '0;
            pack_q  <= '0;
            addr_q  <= '0;
          end
        end
        FILL: begin
          if (beat_acc) begin
            pack_q <= pack_d;
            // Framing mismatches are only flagged; the frame length is fixed by the address space.
            if (s_axis_tlast != final_beat) begin
              err_q <= 1'b1;
            end
            if (word_end) begin
              beat_q <= '0;
              we_q   <= 1'b1;
              data_q <= pack_d;
              addr_q <= addr_d;
              word_q <= word_q + ADDR_WIDTH'(1);
              if (word_q == LAST_WORD) begin
                state_q <= FLUSH;
              end
            end else begin
              beat_q <= beat_q + BW'(1);
            end
          end
        end
        FLUSH: begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign we        = we_q;
  assign w_addr    = addr_q;
  assign w_data    = data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign tlast_err = err_q;

endmodule

// File: tb/tb_axis2ram_wr.sv
`timescale 1ns/1ps
// Bench for axis2ram_wr: per-cycle comparison against a beat-count reference model, plus literal frame checks.
module tb_axis2ram_wr;

  localparam int AW    = 3;
  localparam int DW    = 64;
  localparam int IW    = 32;
  localparam int PACK  = DW / IW;
  localparam int NW    = 1 << AW;
  localparam int TOTAL = PACK * NW;

  logic          clk;
  logic          srstn;
  logic          start;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [IW-1:0] s_axis_tdata;
  logic          s_axis_tlast;
  logic          we;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic          busy;
  logic          done;
  logic          tlast_err;

  axis2ram_wr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IN_WIDTH(IW)) dut (
    .clk(clk), .srstn(srstn), .start(start),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .we(we), .w_addr(w_addr), .w_data(w_data),
    .busy(busy), .done(done), .tlast_err(tlast_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: counts accepted beats per frame and derives every output from that count.
  bit            m_started;
  int            m_beats;
  int            m_post;
  logic [IW-1:0] mb [TOTAL];
  logic          e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  logic          e_busy, e_done, e_err;

  logic [AW-1:0] wlog_a [$];
  logic [DW-1:0] wlog_d [$];

  function automatic logic [AW-1:0] map_addr(input int w);
    logic [AW-1:0] a;
    logic [AW-1:0] r;
    a = AW'(w);
`ifdef AXIS2RAM_BITREV_ADDR_EN
    for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
`else
    r = a;
`endif
    return r;
  endfunction

  task automatic model_reset();
    m_started = 0; m_beats = 0; m_post = 0;
    e_we = 0; e_addr = '0; e_data = '0; e_busy = 0; e_done = 0; e_err = 0;
  endtask

  task automatic model_step();
    bit tr, can_start;
    int b;
    tr        = m_started && (m_beats < TOTAL);
    can_start = !m_started || (m_beats == TOTAL && m_post >= 1);
    e_we = 0;
    if (start && can_start) begin
      m_started = 1; m_beats = 0; m_post = 0;
      e_busy = 1; e_done = 0; e_err = 0; e_addr = '0;
    end else if (tr && s_axis_tvalid) begin
      b = m_beats;
      mb[b] = s_axis_tdata;
      if (s_axis_tlast !== 1'(b == TOTAL - 1)) e_err = 1;
      if ((b + 1) % PACK == 0) begin
        e_we   = 1;
        e_addr = map_addr(b / PACK);
        for (int k = 0; k < PACK; k++) e_data[k*IW +: IW] = mb[b - PACK + 1 + k];
      end
      m_beats = b + 1;
      m_post  = 0;
    end else if (m_started && m_beats == TOTAL && m_post < 2) begin
      m_post++;
      if (m_post == 1) begin
        e_busy = 0;
        e_done = 1;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!srstn) model_reset(); else model_step();
      @(negedge clk);
      if (!srstn) model_reset();
      chk("tready", s_axis_tready, 1'(m_started && (m_beats < TOTAL)));
      chk("we",     we,        e_we);
      chk("w_addr", w_addr,    e_addr);
      chk("w_data", w_data,    e_data);
      chk("busy",   busy,      e_busy);
      chk("done",   done,      e_done);
      chk("err",    tlast_err, e_err);
      if (we === 1'b1) begin
        wlog_a.push_back(w_addr);
        wlog_d.push_back(w_data);
      end
    end
  end

  // Stimulus: inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 0;
    repeat (n) step();
  endtask

  task automatic pulse_start();
    start = 1; step(); start = 0;
  endtask

  task automatic send_beat(input logic [IW-1:0] d, input logic l);
    int t;
    bit acc;
    t = 0; acc = 0;
    s_axis_tvalid = 1; s_axis_tdata = d; s_axis_tlast = l;
    do begin
      @(negedge clk); acc = s_axis_tready;
      step(); t++;
    end while (!acc && t < 200);
    chk("beat_accept", acc, 1);
    s_axis_tvalid = 0; s_axis_tlast = 0;
  endtask

  task automatic send_frame(input int i0, input int i1, input int gap, input bit rnd,
                            input logic [IW-1:0] base, input int bad_at, input bit omit_last,
                            input int start_at);
    logic [IW-1:0] d;
    logic l;
    for (int i = i0; i < i1; i++) begin
      if (gap == 1 && i > i0) idle(1);
      else if (gap == 2) idle($urandom_range(0, 2));
      d = rnd ? IW'($urandom) : base + IW'(i);
      l = ((i == TOTAL - 1) && !omit_last) || (i == bad_at);
      if (i == start_at) start = 1;
      send_beat(d, l);
      start = 0;
    end
  endtask

  task automatic wait_done(input string nm);
    int t;
    t = 0;
    while (done !== 1'b1 && t < 50) begin step(); t++; end
    chk(nm, done, 1);
  endtask

  task automatic clear_log();
    wlog_a.delete(); wlog_d.delete();
  endtask

  logic [AW-1:0] lit_addr [NW];
  logic [DW-1:0] word0, word7;

  task automatic chk_linear_frame(input string nm);
    chk({nm, "_nwr"}, wlog_a.size(), NW);
    if (wlog_a.size() == NW) begin
      for (int i = 0; i < NW; i++) chk({nm, "_addr"}, wlog_a[i], lit_addr[i]);
      chk({nm, "_word0"}, wlog_d[0], 64'h00000001_00000000);
      chk({nm, "_word7"}, wlog_d[7], 64'h0000000F_0000000E);
    end
  endtask

  initial begin
`ifdef AXIS2RAM_BITREV_ADDR_EN
    lit_addr = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
`else
    lit_addr = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
`endif
    srstn = 0; start = 0; s_axis_tvalid = 0; s_axis_tdata = '0; s_axis_tlast = 0;
    repeat (3) step();
    chk("rst_we", we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", w_addr, 0);
    srstn = 1;
    idle(2);

    // Continuous frame with counting data.
    clear_log();
    pulse_start();
    send_frame(0, TOTAL, 0, 0, 32'h0, -1, 0, -1);
    @(negedge clk);
    chk("s1_flush_we", we, 1);
    chk("s1_flush_done", done, 0);
    chk("s1_flush_addr", w_addr, lit_addr[NW-1]);
    step();
    chk("s1_done", done, 1);
    chk("s1_busy", busy, 0);
    chk("s1_err", tlast_err, 0);
    chk_linear_frame("s1");

    // Same data with tvalid gaps between beats.
    idle(2);
    clear_log();
    pulse_start();
    send_frame(0, TOTAL, 1, 0, 32'h0, -1, 0, -1);
    wait_done("s2_done");
    chk("s2_err", tlast_err, 0);
    chk_linear_frame("s2");

    // Early tlast on beat 5, missing tlast on the final beat.
    clear_log();
    pulse_start();
    send_frame(0, 5, 0, 0, 32'h20, 5, 1, -1);
    chk("s3_err_before", tlast_err, 0);
    send_frame(5, 6, 0, 0, 32'h20, 5, 1, -1);
    chk("s3_err_after", tlast_err, 1);
    send_frame(6, TOTAL, 0, 0, 32'h20, 5, 1, -1);
    wait_done("s3_done");
    chk("s3_err_end", tlast_err, 1);
    chk("s3_nwr", wlog_a.size(), NW);

    // Reset in the middle of a frame, then a clean frame.
    pulse_start();
    send_frame(0, 6, 0, 0, 32'h40, -1, 0, -1);
    srstn = 0; #1;
    chk("s4_rst_busy", busy, 0);
    chk("s4_rst_tready", s_axis_tready, 0);
    chk("s4_rst_data", w_data, 0);
    chk("s4_rst_addr", w_addr, 0);
    repeat (2) step();
    srstn = 1;
    idle(1);
    clear_log();
    pulse_start();
    send_frame(0, TOTAL, 0, 0, 32'h100, -1, 0, -1);
    wait_done("s4_done");
    chk("s4_nwr", wlog_a.size(), NW);
    if (wlog_a.size() > 0) begin
      chk("s4_addr0", wlog_a[0], 0);
      chk("s4_word0", wlog_d[0], 64'h00000101_00000100);
    end

    // Start during FILL is ignored; start after done clears status.
    clear_log();
    pulse_start();
    send_frame(0, TOTAL, 0, 0, 32'h200, 3, 0, 8);
    wait_done("s5_done");
    chk("s5_err", tlast_err, 1);
    chk("s5_nwr", wlog_a.size(), NW);
    pulse_start();
    chk("s5_restart_done", done, 0);
    chk("s5_restart_err", tlast_err, 0);
    chk("s5_restart_addr", w_addr, 0);
    chk("s5_restart_busy", busy, 1);
    send_frame(0, TOTAL, 2, 1, 32'h0, -1, 0, -1);
    wait_done("s5_done2");

    // Random frames, random gaps and data, occasional framing errors, excess beats.
    for (int r = 0; r < 8; r++) begin
      idle($urandom_range(0, 3));
      clear_log();
      pulse_start();
      send_frame(0, TOTAL, 2, 1, 32'h0,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TOTAL - 2)) : -1,
                 ($urandom_range(0, 3) == 0), -1);
      s_axis_tvalid = 1;
      repeat (3) step();
      s_axis_tvalid = 0;
      wait_done("rnd_done");
      chk("rnd_nwr", wlog_a.size(), NW);
    end
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
